thread_scheduler: RTL

THREAD_SCHEDULER -- requirements
Module: thread_scheduler

---
 rtl/thread_scheduler.sv | 138 +++++++++++++
 1 files changed

// File: rtl/thread_scheduler.sv
// Round-robin thread scheduler feeding a single join-execute core, one instruction in flight.
// Optional watchdog on the WAIT state is built when SCHED_TIMEOUT_EN is defined.
module thread_scheduler #(
   parameter int NUM_THREADS = 4,
   parameter int PC_W        = 8,
   parameter int PROG_LEN    = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [NUM_THREADS-1:0]         start_mask,
   output logic                           busy,
   output logic                           done,
   output logic                           issue_valid,
   input  logic                           issue_ready,
   output logic [$clog2(NUM_THREADS)-1:0] issue_thread,
   output logic [PC_W-1:0]                instruction,
   input  logic                           commit_valid,
   input  logic [PC_W-1:0]                instruction_post,
   output logic                           err
);

   localparam int TW = $clog2(NUM_THREADS);
   localparam logic [PC_W-1:0] PROG_END = PC_W'(PROG_LEN);

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      ISSUE,
      WAIT,
      FIN
   } state_t;

   state_t                 state, state_nxt;
   logic [NUM_THREADS-1:0] active;
   logic [PC_W-1:0]        pc [NUM_THREADS];
   logic [TW-1:0]          rr_ptr;
   logic [TW-1:0]          cur;
   logic                   sel_found;
   logic [TW-1:0]          sel_idx;
   logic                   commit_fire;
   logic                   timeout;

   assign commit_fire = (state == WAIT) && commit_valid;

   // First active slot at or after rr_ptr; the TW-bit add wraps modulo NUM_THREADS.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      sel_found = 1'b0;
      sel_idx   = rr_ptr;
      for (int k = 0; k < NUM_THREADS; k++) begin
         if (!sel_found && active[rr_ptr + TW'(k)]) begin
            sel_found = 1'b1;
            sel_idx   = rr_ptr + TW'(k);
         end
      end
   end

`ifdef SCHED_TIMEOUT_EN
   logic [7:0] wd_cnt;

   // The counter sits at 0 on the first WAIT cycle, so 254 marks the 255th cycle without a commit.
   assign timeout = (state == WAIT) && !commit_valid && (wd_cnt == 8'd254);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= 8'd0;
         err    <= 1'b0;
      end else begin
         if (state != WAIT || commit_valid) wd_cnt <= 8'd0;
         else                               wd_cnt <= wd_cnt + 8'd1;
         if (timeout) err <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = (|start_mask) ? SELECT : FIN;
         SELECT:  state_nxt = sel_found ? ISSUE : FIN;
         ISSUE:   if (issue_ready) state_nxt = WAIT;
         WAIT:    if (commit_fire || timeout) state_nxt = SELECT;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active <= '0;
         // NOTE: the PC file is small and must read as 0 out of reset, so it is reset like any flop.
         for (int i = 0; i < NUM_THREADS; i++) pc[i] <= '0;
         rr_ptr <= '0;
         cur    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start && |start_mask) begin
                  active <= start_mask;
                  for (int i = 0; i < NUM_THREADS; i++) pc[i] <= '0;
                  rr_ptr <= '0;
               end
            end
            SELECT: begin
               if (sel_found) cur <= sel_idx;
            end
            WAIT: begin
               if (commit_fire) begin
                  pc[cur] <= instruction_post;
                  if (instruction_post >= PROG_END) active[cur] <= 1'b0;
                  rr_ptr <= cur + 1'b1;
               end else if (timeout) begin
                  active[cur] <= 1'b0;
                  rr_ptr      <= cur + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy         = (state != IDLE);
   assign done         = (state == FIN);
   assign issue_valid  = (state == ISSUE);
   assign issue_thread = cur;
   assign instruction  = pc[cur];

endmodule
